// File: rtl/alu_issue_stage.sv
// RV32I decode-and-issue stage: decodes instruction + register operands into
// ALU control/operands and issues them to EX through a 2-entry valid/ready buffer.
module alu_issue_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_inst,
  input  logic [31:0] in_pc,
  input  logic [31:0] in_rs1_data,
  input  logic [31:0] in_rs2_data,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [4:0]  out_alu_ctrl,
  output logic [31:0] out_op1,
  output logic [31:0] out_op2,
  output logic [31:0] out_store_data,
  output logic [31:0] out_target,
  output logic [31:0] out_link,
  output logic [4:0]  out_rd,
  output logic        out_reg_write,
  output logic        out_mem_read,
  output logic        out_mem_write,
  output logic        out_is_branch,
  output logic        out_is_jump,
  output logic        out_illegal
);

  localparam logic [4:0] ALU_ADD = 5'd0,  ALU_SUB = 5'd1,  ALU_SLL = 5'd2,  ALU_SLT = 5'd3;
  localparam logic [4:0] ALU_SLTU = 5'd4, ALU_XOR = 5'd5,  ALU_SRL = 5'd6,  ALU_SRA = 5'd7;
  localparam logic [4:0] ALU_OR = 5'd8,   ALU_AND = 5'd9,  ALU_JALR = 5'd10, ALU_BEQ = 5'd11;
  localparam logic [4:0] ALU_BNE = 5'd12, ALU_BLT = 5'd13, ALU_BGE = 5'd14, ALU_BLTU = 5'd15;
  localparam logic [4:0] ALU_BGEU = 5'd16, ALU_IMM = 5'd17;

  typedef struct packed {
    logic [4:0]  ctrl;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [31:0] store_data;
    logic [31:0] target;
    logic [31:0] link;
    logic [4:0]  rd;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        is_branch;
    logic        is_jump;
    logic        illegal;
  } entry_t;

  entry_t      dec;
  entry_t      head;
  entry_t      buf_q [2];
  logic        wr_ptr, rd_ptr;
  logic [1:0]  count, count_nx;
  logic        in_ready_q;
  logic        push, pop;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        alt;
  logic        rw_en;
  logic [4:0]  arith;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  assign opcode = in_inst[6:0];
  assign funct3 = in_inst[14:12];
  assign alt    = in_inst[30];
  assign imm_i  = {{20{in_inst[31]}}, in_inst[31:20]};
  assign imm_s  = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
  assign imm_b  = {{19{in_inst[31]}}, in_inst[31], in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0};
  assign imm_u  = {in_inst[31:12], 12'b0};
  assign imm_j  = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0};

  // Shared funct3 -> ALU code map for R-type and I-ALU; Sub is only decoded for R-type.
  always_comb begin
    arith = ALU_ADD;
    case (funct3)
      3'b000: arith = ALU_ADD;
      3'b001: arith = ALU_SLL;
      3'b010: arith = ALU_SLT;
      3'b011: arith = ALU_SLTU;
      3'b100: arith = ALU_XOR;
      3'b101: arith = alt ? ALU_SRA : ALU_SRL;
      3'b110: arith = ALU_OR;
      default: arith = ALU_AND;
    endcase
  end

  always_comb begin
    dec            = '0;
    dec.ctrl       = ALU_ADD;
    dec.op1        = in_rs1_data;
    dec.op2        = in_rs2_data;
    dec.store_data = in_rs2_data;
    dec.target     = in_pc + ((opcode == 7'b1101111) ? imm_j : imm_b);
    dec.link       = in_pc + 32'd4;
    dec.rd         = in_inst[11:7];
    rw_en          = 1'b0;
    case (opcode)
      7'b0110011: begin
        dec.ctrl = (funct3 == 3'b000 && alt) ? ALU_SUB : arith;
        rw_en    = 1'b1;
      end
      7'b0010011: begin
        dec.ctrl = arith;
        dec.op2  = (funct3 == 3'b001 || funct3 == 3'b101) ? {27'b0, in_inst[24:20]} : imm_i;
        rw_en    = 1'b1;
      end
      7'b0000011: begin
        dec.op2      = imm_i;
        dec.mem_read = 1'b1;
        rw_en        = 1'b1;
      end
      7'b0100011: begin
        dec.op2       = imm_s;
        dec.mem_write = 1'b1;
      end
      7'b0110111: begin
        dec.ctrl = ALU_IMM;
        dec.op2  = imm_u;
        rw_en    = 1'b1;
      end
      7'b0010111: begin
        dec.op1 = in_pc;
        dec.op2 = imm_u;
        rw_en   = 1'b1;
      end
      7'b1101111: begin
        dec.op1     = in_pc;
        dec.op2     = 32'd4;
        dec.is_jump = 1'b1;
        rw_en       = 1'b1;
      end
      7'b1100111: begin
        dec.ctrl    = ALU_JALR;
        dec.op2     = imm_i;
        dec.is_jump = 1'b1;
        rw_en       = 1'b1;
      end
      7'b1100011: begin
        dec.is_branch = 1'b1;
        case (funct3)
          3'b000: dec.ctrl = ALU_BEQ;
          3'b001: dec.ctrl = ALU_BNE;
          3'b100: dec.ctrl = ALU_BLT;
          3'b101: dec.ctrl = ALU_BGE;
          3'b110: dec.ctrl = ALU_BLTU;
          3'b111: dec.ctrl = ALU_BGEU;
          default: begin
            dec.is_branch = 1'b0;
            dec.illegal   = 1'b1;
          end
        endcase
      end
      default: dec.illegal = 1'b1;
    endcase
    dec.reg_write = rw_en && (in_inst[11:7] != 5'd0);
  end

  assign push     = in_valid && in_ready_q;
  assign pop      = (count != 2'd0) && out_ready;
  assign count_nx = flush ? 2'd0 : (count + {1'b0, push} - {1'b0, pop});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count      <= 2'd0;
      wr_ptr     <= 1'b0;
      rd_ptr     <= 1'b0;
      in_ready_q <= 1'b1;
      for (int i = 0; i < 2; i++) buf_q[i] <= '0;
    end else begin
      count      <= count_nx;
      in_ready_q <= (count_nx != 2'd2);
      if (flush) begin
        wr_ptr <= 1'b0;
        rd_ptr <= 1'b0;
      end else begin
        if (push) begin
          buf_q[wr_ptr] <= dec;
          wr_ptr        <= ~wr_ptr;
        end
        if (pop) rd_ptr <= ~rd_ptr;
      end
    end
  end

  assign head           = buf_q[rd_ptr];
  assign in_ready       = in_ready_q;
  assign out_valid      = (count != 2'd0);
  assign out_alu_ctrl   = head.ctrl;
  assign out_op1        = head.op1;
  assign out_op2        = head.op2;
  assign out_store_data = head.store_data;
  assign out_target     = head.target;
  assign out_link       = head.link;
  assign out_rd         = head.rd;
  assign out_reg_write  = head.reg_write;
  assign out_mem_read   = head.mem_read;
  assign out_mem_write  = head.mem_write;
  assign out_is_branch  = head.is_branch;
  assign out_is_jump    = head.is_jump;
  assign out_illegal    = head.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Randomized bench for alu_issue_stage: a queue-based reference model of the
// decoded-instruction stream, plus directed literal checks that pin the model.
module tb_alu_issue_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0, in_ready;
  logic [31:0] in_inst = '0, in_pc = '0, in_rs1_data = '0, in_rs2_data = '0;
  logic        flush = 1'b0;
  logic        out_valid, out_ready = 1'b0;
  logic [4:0]  out_alu_ctrl, out_rd;
  logic [31:0] out_op1, out_op2, out_store_data, out_target, out_link;
  logic        out_reg_write, out_mem_read, out_mem_write, out_is_branch, out_is_jump, out_illegal;

  int nvec = 0;
  int nerr = 0;

  alu_issue_stage dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_inst(in_inst), .in_pc(in_pc), .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_alu_ctrl(out_alu_ctrl), .out_op1(out_op1), .out_op2(out_op2),
    .out_store_data(out_store_data), .out_target(out_target), .out_link(out_link),
    .out_rd(out_rd), .out_reg_write(out_reg_write), .out_mem_read(out_mem_read),
    .out_mem_write(out_mem_write), .out_is_branch(out_is_branch), .out_is_jump(out_is_jump),
    .out_illegal(out_illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  ctrl;
    logic [31:0] op1, op2, sd, tgt, link;
    logic [4:0]  rd;
    logic        rw, mr, mw, br, jp, il;
    bit          c_op1, c_op2, c_tgt, c_sd;
  } exp_t;

  exp_t q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference decode written straight from the instruction-set rules.
  function automatic exp_t model(input logic [31:0] inst, input logic [31:0] pc,
                                 input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    int   f3 = int'(inst[14:12]);
    int   arith_map[8] = '{0, 2, 3, 4, 5, 6, 8, 9};
    int   br_map[8]    = '{11, 12, -1, -1, 13, 14, 15, 16};
    int   imm_i = int'($signed(inst[31:20]));
    int   imm_s = int'($signed({inst[31:25], inst[11:7]}));
    int   imm_b = int'($signed({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}));
    int   imm_j = int'($signed({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}));
    logic [31:0] imm_u = {inst[31:12], 12'h000};
    bit   writes = 0;
    e = '{ctrl: 0, op1: a, op2: b, sd: b, tgt: 0, link: pc + 4, rd: inst[11:7],
           rw: 0, mr: 0, mw: 0, br: 0, jp: 0, il: 0,
           c_op1: 1, c_op2: 1, c_tgt: 0, c_sd: 0};
    case (inst[6:0])
      7'h33: begin
        e.ctrl = 5'(arith_map[f3]);
        if (f3 == 0 && inst[30]) e.ctrl = 1;
        if (f3 == 5 && inst[30]) e.ctrl = 7;
        writes = 1;
      end
      7'h13: begin
        e.ctrl = 5'(arith_map[f3]);
        if (f3 == 5 && inst[30]) e.ctrl = 7;
        e.op2 = (f3 == 1 || f3 == 5) ? 32'(inst[24:20]) : 32'(imm_i);
        writes = 1;
      end
      7'h03: begin e.op2 = 32'(imm_i); e.mr = 1; writes = 1; end
      7'h23: begin e.op2 = 32'(imm_s); e.mw = 1; e.c_sd = 1; end
      7'h37: begin e.ctrl = 17; e.op2 = imm_u; e.c_op1 = 0; writes = 1; end
      7'h17: begin e.op1 = pc; e.op2 = imm_u; writes = 1; end
      7'h6F: begin
        e.op1 = pc; e.op2 = 4; e.jp = 1; writes = 1;
        e.tgt = pc + 32'(imm_j); e.c_tgt = 1;
      end
      7'h67: begin e.ctrl = 10; e.op2 = 32'(imm_i); e.jp = 1; writes = 1; end
      7'h63: begin
        if (br_map[f3] < 0) begin
          e.il = 1; e.c_op1 = 0; e.c_op2 = 0;
        end else begin
          e.ctrl = 5'(br_map[f3]); e.br = 1;
          e.tgt = pc + 32'(imm_b); e.c_tgt = 1;
        end
      end
      default: begin e.il = 1; e.c_op1 = 0; e.c_op2 = 0; end
    endcase
    e.rw = writes && (inst[11:7] != 0);
    return e;
  endfunction

  task automatic compare_all();
    chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
    chk("in_ready", 32'(in_ready), 32'(q.size() < 2));
    if (q.size() != 0) begin
      exp_t e = q[0];
      chk("ctrl", 32'(out_alu_ctrl), 32'(e.ctrl));
      chk("rd", 32'(out_rd), 32'(e.rd));
      chk("flags", {26'b0, out_reg_write, out_mem_read, out_mem_write, out_is_branch, out_is_jump, out_illegal},
          {26'b0, e.rw, e.mr, e.mw, e.br, e.jp, e.il});
      chk("link", out_link, e.link);
      if (e.c_op1) chk("op1", out_op1, e.op1);
      if (e.c_op2) chk("op2", out_op2, e.op2);
      if (e.c_tgt) chk("target", out_target, e.tgt);
      if (e.c_sd) chk("store_data", out_store_data, e.sd);
    end
  endtask

  // One cycle: check outputs, drive new inputs, advance the model, take the edge.
  task automatic step(input bit v, input logic [31:0] inst, input logic [31:0] pc,
                      input logic [31:0] a, input logic [31:0] b, input bit fl, input bit ordy);
    int sz;
    @(negedge clk);
    compare_all();
    in_valid = v; in_inst = inst; in_pc = pc; in_rs1_data = a; in_rs2_data = b;
    flush = fl; out_ready = ordy;
    sz = q.size();
    if (fl) q.delete();
    else begin
      if (ordy && sz > 0) void'(q.pop_front());
      if (v && sz < 2) q.push_back(model(inst, pc, a, b));
    end
    @(posedge clk);
    #2;
  endtask

  function automatic logic [31:0] rand_inst();
    logic [6:0] ops[10] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h00};
    logic [31:0] w = $urandom;
    int k = $urandom_range(0, 9);
    if (k < 9) w[6:0] = ops[k];
    return w;
  endfunction

  initial begin
    #12 rst_n = 1'b1;
    @(posedge clk); #2;

    // add x3,x1,x2
    step(1, 32'h002081B3, 32'h0000_0040, 5, 7, 0, 1);
    chk("add ctrl", 32'(out_alu_ctrl), 0);
    chk("add op1", out_op1, 5);
    chk("add op2", out_op2, 7);
    chk("add rd", 32'(out_rd), 3);
    chk("add rw", 32'(out_reg_write), 1);
    // srai x5,x6,4
    step(1, 32'h40435293, 32'h0000_0044, 32'h8000_0000, 0, 0, 1);
    chk("srai ctrl", 32'(out_alu_ctrl), 7);
    chk("srai op2", out_op2, 4);
    // lui x1,0x12345
    step(1, 32'h123450B7, 32'h0000_0048, 0, 0, 0, 1);
    chk("lui ctrl", 32'(out_alu_ctrl), 17);
    chk("lui op2", out_op2, 32'h1234_5000);
    // bge x1,x2,-8
    step(1, 32'hFE20DCE3, 32'h0000_0100, 1, 2, 0, 1);
    chk("bge ctrl", 32'(out_alu_ctrl), 14);
    chk("bge target", out_target, 32'h0000_00F8);
    chk("bge br", 32'(out_is_branch), 1);
    chk("bge rw", 32'(out_reg_write), 0);
    step(0, 0, 0, 0, 0, 0, 1);

    // backpressure: add x1/x2/x3 back to back with out_ready low
    step(1, 32'h002080B3, 32'h200, 1, 1, 0, 0);
    step(1, 32'h00208133, 32'h204, 2, 2, 0, 0);
    chk("bp ready after 2", 32'(in_ready), 0);
    step(1, 32'h002081B3, 32'h208, 3, 3, 0, 0);
    chk("bp head rd", 32'(out_rd), 1);
    step(1, 32'h002081B3, 32'h208, 3, 3, 0, 1);
    chk("bp head after pop", 32'(out_rd), 2);
    chk("bp ready after pop", 32'(in_ready), 1);
    step(1, 32'h002081B3, 32'h208, 3, 3, 0, 1);
    chk("bp third rd", 32'(out_rd), 3);
    step(0, 0, 0, 0, 0, 0, 1);

    // flush with full buffer and incoming entry
    step(1, 32'h002080B3, 32'h300, 1, 1, 0, 0);
    step(1, 32'h00208133, 32'h304, 2, 2, 0, 0);
    step(1, 32'h002081B3, 32'h308, 3, 3, 1, 0);
    chk("flush valid", 32'(out_valid), 0);
    chk("flush ready", 32'(in_ready), 1);
    step(0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 1);

    // illegal opcode 0x7F
    step(1, 32'hFFFF_FFFF, 32'h400, 9, 9, 0, 0);
    chk("illegal flag", 32'(out_illegal), 1);
    chk("illegal other flags", {27'b0, out_reg_write, out_mem_read, out_mem_write, out_is_branch, out_is_jump}, 0);
    chk("illegal ctrl", 32'(out_alu_ctrl), 0);
    step(1, 32'h002081B3, 32'h404, 3, 3, 0, 0);

    // asynchronous reset mid-stream, away from any clock edge
    #1 rst_n = 1'b0;
    #1;
    chk("rst valid", 32'(out_valid), 0);
    chk("rst ready", 32'(in_ready), 1);
    chk("rst data", out_op1 | out_op2 | out_store_data | out_target | out_link, 0);
    chk("rst ctl", {16'b0, out_alu_ctrl, out_rd, out_reg_write, out_mem_read, out_mem_write,
                    out_is_branch, out_is_jump, out_illegal}, 0);
    q.delete();
    in_valid = 0; flush = 0; out_ready = 0;
    @(negedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #2;

    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 9) < 7, rand_inst(), $urandom, $urandom, $urandom,
           $urandom_range(0, 99) < 3, $urandom_range(0, 9) < 6);
    end
    step(0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/alu_issue_stage.md
# alu_issue_stage

Decode-and-issue stage that produces the ALU's inputs. Decodes an RV32I instruction plus register-file read data into the 5-bit ALU control code and the two ALU operands, with store data, destination and control flags. Issues them through a 2-entry valid/ready buffer into the EX stage. Sits between the register-file read (ID) and the ALU (EX), and supports pipeline flush on branch or jump redirect.

## Interface
- No parameters; data width fixed at 32, ALU control width fixed at 5.
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  ID offers an instruction
- in_ready  out  1  stage can accept (registered)
- in_inst  in  32  RV32I instruction word
- in_pc  in  32  instruction address
- in_rs1_data / in_rs2_data  in  32  register-file values for inst[19:15] / inst[24:20]
- flush  in  1  discard all buffered and incoming entries
- out_valid  out  1  head entry available to EX
- out_ready  in  1  EX consumes head entry
- out_alu_ctrl  out  5  ALU control code
- out_op1 / out_op2  out  32  ALU operands
- out_store_data  out  32  rs2 data for stores
- out_target  out  32  pc + B/J immediate (branch/JAL target)
- out_link  out  32  pc + 4
- out_rd  out  5  destination register
- out_reg_write, out_mem_read, out_mem_write, out_is_branch, out_is_jump, out_illegal  out  1 each  control flags

## Operation
- ALU codes (fixed): Add 0, Sub 1, Sll 2, Slt 3, Sltu 4, Xor 5, Srl 6, Sra 7, Or 8, And 9, Jalr 10, Beq 11, Bne 12, Blt 13, Bge 14, Bltu 15, Bgeu 16, Imm 17.
- R-type (0110011): op1=rs1, op2=rs2. Code comes from funct3 with funct7[5]: Sub for 000, Sra for 101.
- I-ALU (0010011): op2=sign-extended inst[31:20]. For shifts, op2={27'b0, inst[24:20]}, and inst[30] selects Sra vs Srl.
- Load (0000011): Add, op2=I-imm, mem_read=1. Store (0100011): Add, op2=S-imm, mem_write=1, store_data=rs2, reg_write=0.
- LUI: Imm, op2={inst[31:12],12'b0}. AUIPC: Add, op1=pc, op2=U-imm.
- JAL: Add, op1=pc, op2=4, is_jump=1, target=pc+J-imm. JALR: Jalr, op1=rs1, op2=I-imm, is_jump=1.
- Branch (1100011): op1=rs1, op2=rs2, reg_write=0, is_branch=1, target=pc+B-imm. funct3 000/001/100/101/110/111 map to Beq/Bne/Blt/Bge/Bltu/Bgeu.
- Any other opcode, or branch funct3 010/011: out_illegal=1, Add, all write/mem/branch/jump flags 0.
- reg_write=1 only for R, I-ALU, load, LUI, AUIPC, JAL, JALR, and only when rd!=0. Otherwise out_rd=inst[11:7] unchanged.
- All immediates are sign-extended to 32 bits. pc+4 and targets wrap modulo 2^32.
- Buffer: 2-entry FIFO of decoded entries with count 0..2.
  - Push when in_valid && in_ready. Pop when out_valid && out_ready.
  - in_ready = (count<2), registered from the next-count value.
  - out_valid = (count!=0). Outputs always show the head entry.
  - Simultaneous push and pop at count 1 or 2: count unchanged, order preserved.
- flush (sync): on the next edge count becomes 0 and a concurrent push is dropped. flush has priority over push and pop.

## Timing
- Latency: an entry accepted at edge N is visible on outputs after edge N; out_valid is high in cycle N+1 when the buffer was empty.
- Throughput: 1 instruction per cycle while out_ready=1.
- Backpressure: with out_ready=0, two entries are accepted and then in_ready=0 from the cycle after the second push.
- Reset (async, rst_n=0): count=0, out_valid=0, in_ready=1, all data outputs and flags 0. Entries in flight are lost; operation resumes on the first edge after rst_n rises.
- No combinational path from in_* or out_ready to in_ready. Outputs are combinational only from the buffer head pointer and storage.

## Test plan
- add x3,x1,x2 (0x002081B3) with rs1=5, rs2=7 -> next cycle ctrl=0, op1=5, op2=7, rd=3, reg_write=1.
- srai x5,x6,4 (0x40435293) with rs1=0x80000000 -> ctrl=7, op2=4. lui x1,0x12345 (0x123450B7) -> ctrl=17, op2=0x12345000.
- bge x1,x2,-8 (0xFE20DCE3) at pc=0x100 -> ctrl=14, target=0xF8, is_branch=1, reg_write=0.
- out_ready=0 with 3 back-to-back pushes -> 2 accepted, in_ready=0. Then raise out_ready -> entries drain in order, and the third is accepted the cycle after the first pop.
- flush asserted with count=2 and in_valid=1 -> next cycle out_valid=0, in_ready=1, and the incoming entry never appears.
- Opcode 0x7F, plus rst_n pulsed low mid-stream -> out_illegal=1 with all flags 0, and on reset all outputs 0 immediately without waiting for a clock.
